my_softcore_cpu_cpu_ocimem_arbiter: RTL

Arbitrates the 256×32 on-chip debug RAM (OCI memory) between two requesters: the CPU's Avalon debug-memory slave port and the JTAG debug slave's sysclk-side action strobes. It sits next to the debug slave wrapper in the CPU's sysclk domain and consumes its `take_action_ocimem_a`, `take_action_ocimem_b`, `take_no_action_ocimem_a` and `jdo` outputs. It returns read data to the debugger via `MonDReg`. JTAG strobes are captured so none is lost, and service alternates between requesters so neither starves.

---
 rtl/my_softcore_cpu_cpu_ocimem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/my_softcore_cpu_cpu_ocimem_arbiter.sv
`default_nettype none
// my_softcore_cpu_cpu_ocimem_arbiter: shares the 256x32 OCI debug RAM between the Avalon
// debug slave and the JTAG action strobes, with fair alternation.  Rev 1.0
module my_softcore_cpu_cpu_ocimem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  input  logic [7:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [7:0]  ram_addr,
  output logic        ram_wren,
  output logic [3:0]  ram_byteen,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [31:0] MonDReg,
  output logic        jtag_rd_done,
  output logic        jtag_overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AV_RD = 2'd1,
    S_JT_RD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  jt_addr_q, jt_addr_d;
  logic [31:0] jt_wdata_q, jt_wdata_d;
  logic        jt_wr_pend_q, jt_wr_pend_d;
  logic        jt_rd_pend_q, jt_rd_pend_d;
  logic        last_jtag_q, last_jtag_d;
  logic [31:0] mon_q, mon_d;
  logic        overrun_q, overrun_d;

  logic jt_wr_done, jt_rd_done, av_done;
  logic jt_elig, av_elig, jt_win;
  logic wr_set, wr_ovr, rd_ovr;
  logic unused_jdo_bits;

  assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

  assign jt_elig = jt_wr_pend_q | jt_rd_pend_q;
  assign av_elig = avs_read | avs_write;
  assign jt_win  = jt_elig & (~av_elig | ~last_jtag_q);

  always_comb begin
    state_d         = state_q;
    ram_addr        = jt_addr_q;
    ram_wren        = 1'b0;
    ram_byteen      = 4'hF;
    ram_wdata       = jt_wdata_q;
    avs_waitrequest = av_elig;
    jt_wr_done      = 1'b0;
    jt_rd_done      = 1'b0;
    av_done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (jt_win) begin
          if (jt_wr_pend_q) begin
            ram_wren   = 1'b1;
            jt_wr_done = 1'b1;
          end else begin
            state_d = S_JT_RD;
          end
        end else if (avs_read) begin
          // A simultaneous (illegal) write stays stalled behind the read.
          ram_addr = avs_address;
          state_d  = S_AV_RD;
        end else if (avs_write) begin
          ram_addr        = avs_address;
          ram_wren        = 1'b1;
          ram_byteen      = avs_byteenable;
          ram_wdata       = avs_writedata;
          avs_waitrequest = 1'b0;
          av_done         = 1'b1;
        end
      end
      S_AV_RD: begin
        avs_waitrequest = 1'b0;
        av_done         = 1'b1;
        state_d         = S_IDLE;
      end
      S_JT_RD: begin
        jt_rd_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign avs_readdata = ram_rdata;
  assign jtag_rd_done = jt_rd_done;
  assign MonDReg      = mon_q;
  assign jtag_overrun = overrun_q;

  // A write strobe coinciding with an address load is dropped as an overrun.
  assign wr_set = take_action_ocimem_b & ~take_action_ocimem_a;
  assign wr_ovr = take_action_ocimem_b &
                  (take_action_ocimem_a | (jt_wr_pend_q & ~jt_wr_done));
  assign rd_ovr = take_no_action_ocimem_a & jt_rd_pend_q & ~jt_rd_done;

  always_comb begin
    jt_addr_d    = jt_addr_q;
    jt_wdata_d   = jt_wdata_q;
    jt_wr_pend_d = (jt_wr_pend_q & ~jt_wr_done) | wr_set;
    jt_rd_pend_d = (jt_rd_pend_q & ~jt_rd_done) | take_no_action_ocimem_a;
    last_jtag_d  = last_jtag_q;
    mon_d        = mon_q;
    overrun_d    = overrun_q | wr_ovr | rd_ovr;
    // A fresh address load takes precedence over post-access increment.
    if (take_action_ocimem_a) begin
      jt_addr_d = jdo[33:26];
    end else if (jt_wr_done | jt_rd_done) begin
      jt_addr_d = jt_addr_q + 8'd1;
    end
    if (wr_set) begin
      jt_wdata_d = jdo[34:3];
    end
    if (jt_wr_done | jt_rd_done) begin
      last_jtag_d = 1'b1;
    end else if (av_done) begin
      last_jtag_d = 1'b0;
    end
    if (jt_rd_done) begin
      mon_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      jt_addr_q    <= 8'd0;
      jt_wdata_q   <= 32'd0;
      jt_wr_pend_q <= 1'b0;
      jt_rd_pend_q <= 1'b0;
      last_jtag_q  <= 1'b0;
      mon_q        <= 32'd0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      jt_addr_q    <= jt_addr_d;
      jt_wdata_q   <= jt_wdata_d;
      jt_wr_pend_q <= jt_wr_pend_d;
      jt_rd_pend_q <= jt_rd_pend_d;
      last_jtag_q  <= last_jtag_d;
      mon_q        <= mon_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule
`default_nettype wire
